// File: rtl/fifo_scrambler.sv
// Bit-serial transmit buffer feeding the 802.11 frame-synchronous scrambler.
// Circular buffer of MEM bits; pops scramble with x^7 + x^4 + 1.
module fifo_scrambler #(
  parameter int         AD           = 16,
  parameter int         MEM          = 4,
  parameter logic [6:0] DEFAULT_SEED = 7'b1011101
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seed_load,
  input  logic [6:0]    seed,
  input  logic          we,
  input  logic          data_in,
  input  logic          re,
  output logic          data_out,
  output logic          valid_out,
  output logic          finished,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [AD-1:0] bits_out
);

  localparam int IW = (MEM > 1) ? $clog2(MEM) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [AD-1:0] wr_q, wr_d;
  logic [AD-1:0] rd_q, rd_d;
  logic [AD-1:0] bits_q, bits_d;
  logic [AD-1:0] occ;
  logic [6:0]    lfsr_q, lfsr_d;
  logic          dout_q, dout_d;
  logic          vld_q, vld_d;
  logic          fin_q, fin_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, fb;
  logic          ram_q [MEM];

  assign occ   = wr_q - rd_q;
  assign full  = (occ == AD'(MEM));
  assign empty = (occ == '0);
  assign push  = we && !full;
  assign pop   = (state_q == RUN) && re && !empty;
  assign fb    = lfsr_q[6] ^ lfsr_q[3];

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    bits_d  = bits_q;
    lfsr_d  = lfsr_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    ovf_d   = ovf_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop) begin
      rd_d   = rd_q + 1'b1;
      bits_d = bits_q + 1'b1;
      lfsr_d = {lfsr_q[5:0], fb};
      dout_d = ram_q[rd_q[IW-1:0]] ^ fb;
      vld_d  = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (seed_load) begin
          state_d = RUN;
          lfsr_d  = (seed == '0) ? DEFAULT_SEED : seed;
          bits_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (bits_q != '0 && empty && !we) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a dropped write is recorded even on the frame-start edge
    if (we && full) ovf_d = 1'b1;
    fin_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      bits_q  <= '0;
      lfsr_q  <= DEFAULT_SEED;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fin_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      bits_q  <= bits_d;
      lfsr_q  <= lfsr_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      fin_q   <= fin_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) ram_q[wr_q[IW-1:0]] <= data_in;
  end

  assign data_out  = dout_q;
  assign valid_out = vld_q;
  assign finished  = fin_q;
  assign overflow  = ovf_q;
  assign bits_out  = bits_q;

endmodule

// File: tb/tb_fifo_scrambler.sv
// Bench for fifo_scrambler: queue/keystream model plus literal anchors.
// Random streams are round-tripped through a reference descrambler.
module tb_fifo_scrambler;

  localparam int         AD  = 16;
  localparam int         MEM = 4;
  localparam logic [6:0] DEF = 7'b1011101;

  typedef bit bq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          seed_load = 1'b0;
  logic [6:0]    seed = '0;
  logic          we = 1'b0;
  logic          data_in = 1'b0;
  logic          re = 1'b0;
  logic          data_out, valid_out, finished, full, empty, overflow;
  logic [AD-1:0] bits_out;

  int npass = 0;
  int ntot  = 0;
  bit chk_en = 0;

  fifo_scrambler #(.AD(AD), .MEM(MEM), .DEFAULT_SEED(DEF)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed),
    .we(we), .data_in(data_in), .re(re), .data_out(data_out),
    .valid_out(valid_out), .finished(finished), .full(full),
    .empty(empty), .overflow(overflow), .bits_out(bits_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Keystream history: element k holds x[n-7+k]; x[n] = x[n-7] ^ x[n-4].
  function automatic bq_t hist_init(input logic [6:0] s);
    bq_t h;
    logic [6:0] e;
    e = (s == '0) ? DEF : s;
    for (int i = 6; i >= 0; i--) h.push_back(e[i]);
    return h;
  endfunction

  function automatic bq_t scram(input logic [6:0] s, input bq_t din);
    bq_t h, o;
    bit x;
    h = hist_init(s);
    foreach (din[i]) begin
      x = h[0] ^ h[3];
      void'(h.pop_front());
      h.push_back(x);
      o.push_back(din[i] ^ x);
    end
    return o;
  endfunction

  // Behavioural model: bit queue, keystream history, frame flag.
  bit mq[$];
  bit ks[$];
  bit m_act = 0, m_vld = 0, m_dat = 0, m_ovf = 0;
  int m_cnt = 0;

  task automatic model_step();
    int  occ, c0;
    bit  mf, me, b, x;
    if (!reset) begin
      mq.delete();
      m_act = 0; m_cnt = 0; m_ovf = 0; m_vld = 0; m_dat = 0;
    end else begin
      occ = mq.size(); mf = (occ == MEM); me = (occ == 0); c0 = m_cnt;
      if (m_act && re && !me) begin
        b = mq.pop_front();
        x = ks[0] ^ ks[3];
        void'(ks.pop_front());
        ks.push_back(x);
        m_dat = b ^ x; m_vld = 1; m_cnt = (m_cnt + 1) % 65536;
      end else m_vld = 0;
      if (we && !mf) mq.push_back(data_in);
      if (!m_act && seed_load) begin
        m_act = 1; ks = hist_init(seed); m_cnt = 0; m_ovf = 0;
      end else if (m_act && c0 != 0 && me && !we) m_act = 0;
      if (we && mf) m_ovf = 1;
    end
  endtask

  always @(posedge clk) model_step();

  bit capq[$];
  always @(negedge clk) if (valid_out) capq.push_back(data_out);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_out", valid_out, m_vld);
      chk("data_out", data_out, m_dat);
      chk("finished", finished, !m_act);
      chk("full", full, mq.size() == MEM);
      chk("empty", empty, mq.size() == 0);
      chk("overflow", overflow, m_ovf);
      chk("bits_out", bits_out, m_cnt);
    end
  end

  task automatic start_frame(input logic [6:0] s, input logic r);
    seed_load = 1; seed = s; we = 0; re = r;
    @(negedge clk);
    seed_load = 0;
  endtask

  task automatic push_bits(input bq_t b, input logic r);
    foreach (b[i]) begin
      we = 1; data_in = b[i]; re = r;
      @(negedge clk);
    end
    we = 0;
  endtask

  task automatic wait_fin();
    int n = 0;
    re = 1;
    while (!finished && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!finished) chk("frame_end_timeout", 0, 1);
  endtask

  task automatic zero_frame_lit();
    logic [15:0] lit;
    bq_t z;
    lit = 16'b0000111011110010;
    for (int i = 0; i < 16; i++) z.push_back(0);
    capq.delete();
    start_frame(7'b1111111, 1);
    push_bits(z, 1);
    wait_fin();
    chk("lit_len", capq.size(), 16);
    for (int i = 0; i < 16 && i < capq.size(); i++)
      chk("lit_bit", capq[i], lit[15-i]);
    chk("lit_bits_out", bits_out, 16);
    chk("lit_finished", finished, 1);
  endtask

  initial begin
    bq_t z8, a, b, snt, dec;
    bq_t p5, p4;
    int pushed;
    logic [6:0] rs;

    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_finished", finished, 1);
    chk("rst_empty", empty, 1);
    chk("rst_bits_out", bits_out, 0);
    reset = 1;
    @(negedge clk);

    zero_frame_lit();

    for (int i = 0; i < 8; i++) z8.push_back(0);
    capq.delete();
    start_frame(7'b0000000, 1); push_bits(z8, 1); wait_fin();
    a = capq;
    chk("zero_seed_ovf", overflow, 0);
    capq.delete();
    start_frame(DEF, 1); push_bits(z8, 1); wait_fin();
    b = capq;
    chk("zero_seed_len", a.size(), 8);
    for (int i = 0; i < 8 && i < a.size() && i < b.size(); i++)
      chk("zero_seed_eq", a[i], b[i]);

    p5 = '{1, 0, 1, 1, 0};
    p4 = '{1, 0, 1, 1};
    capq.delete();
    start_frame(7'h2A, 0);
    push_bits(p5, 0);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    wait_fin();
    chk("ovf_pops", capq.size(), 4);
    a = scram(7'h2A, p4);
    for (int i = 0; i < 4 && i < capq.size(); i++)
      chk("ovf_data", capq[i], a[i]);
    chk("ovf_empty", empty, 1);

    capq.delete();
    start_frame(7'h55, 0);
    push_bits(p4, 0);
    we = 1; re = 1; data_in = 0;
    @(negedge clk);
    we = 0; re = 0;
    chk("fullrw_pop", valid_out, 1);
    chk("fullrw_full", full, 0);
    chk("fullrw_ovf", overflow, 1);
    wait_fin();
    chk("fullrw_total", capq.size(), 4);

    start_frame(7'h11, 0);
    we = 1; re = 1; data_in = 1;
    @(negedge clk);
    we = 0;
    chk("emptyrw_nopop", valid_out, 0);
    @(negedge clk);
    chk("emptyrw_pop", valid_out, 1);
    wait_fin();

    for (int t = 0; t < 3; t++) begin
      rs = 7'($urandom);
      capq.delete(); snt.delete();
      start_frame(rs, 0);
      pushed = 0;
      while (pushed < 64) begin
        re = 1'($urandom);
        seed_load = ($urandom % 16 == 0);
        seed = 7'($urandom);
        if (mq.size() < MEM) begin
          we = 1; data_in = 1'($urandom);
          snt.push_back(data_in); pushed++;
        end else we = 0;
        @(negedge clk);
      end
      we = 0; seed_load = 0;
      wait_fin();
      chk("rt_len", capq.size(), 64);
      dec = scram(rs, capq);
      pushed = 0;
      for (int i = 0; i < dec.size() && i < snt.size(); i++)
        if (dec[i] != snt[i]) pushed++;
      chk("rt_mismatches", pushed, 0);
    end

    a.delete();
    for (int i = 0; i < 6; i++) a.push_back(1'($urandom));
    start_frame(7'h3C, 1);
    push_bits(a, 1);
    chk("mid_pops", bits_out, 5);
    reset = 0;
    @(negedge clk);
    chk("mr_finished", finished, 1);
    chk("mr_empty", empty, 1);
    chk("mr_full", full, 0);
    chk("mr_bits_out", bits_out, 0);
    chk("mr_valid", valid_out, 0);
    chk("mr_data", data_out, 0);
    chk("mr_ovf", overflow, 0);
    reset = 1;
    @(negedge clk);
    zero_frame_lit();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
